// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: prescaled OFF / BINARY / SCAN / BREATHE
// patterns with pause, step strobe and a free-running PWM for breathing.
module led_pattern_gen #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned TICK_DIV = 24_000_000,
  parameter int unsigned PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          mode,
  input  logic                pause,
  output logic [CHANNELS-1:0] led,
  output logic                step
);

  localparam int unsigned PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned POS_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [PRESC_W-1:0]  PRESC_MAX = PRESC_W'(TICK_DIV - 1);
  localparam logic [POS_W-1:0]    POS_MAX   = POS_W'(CHANNELS - 1);
  localparam logic [PWM_BITS-1:0] DUTY_MAX  = '1;
  localparam bit                  SINGLE_CH = (CHANNELS == 1);

  typedef enum logic [1:0] {
    M_OFF     = 2'd0,
    M_BINARY  = 2'd1,
    M_SCAN    = 2'd2,
    M_BREATHE = 2'd3
  } mode_e;

  mode_e               r_mode_q;
  logic [PRESC_W-1:0]  r_presc;
  logic [CHANNELS-1:0] r_cnt;
  logic [POS_W-1:0]    r_pos;
  logic                r_dir_up;
  logic [PWM_BITS-1:0] r_duty;
  logic                r_ddir_up;
  logic [PWM_BITS-1:0] r_pwm;
  logic                r_tick_d;

  logic                w_mode_chg;
  logic                w_tick;
  logic [CHANNELS-1:0] w_pattern;

  assign w_mode_chg = (mode != r_mode_q);
  assign w_tick     = (r_presc == PRESC_MAX) && !pause;

  // Pattern decoded from the current state; registered into led below.
  always_comb begin
    w_pattern = '0;
    case (r_mode_q)
      M_BINARY:  w_pattern = r_cnt;
      M_SCAN:    w_pattern = CHANNELS'(1) << r_pos;
      M_BREATHE: w_pattern = {CHANNELS{r_pwm < r_duty}};
      default:   w_pattern = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode_q  <= M_OFF;
      r_presc   <= '0;
      r_cnt     <= '0;
      r_pos     <= '0;
      r_dir_up  <= 1'b1;
      r_duty    <= '0;
      r_ddir_up <= 1'b1;
      r_pwm     <= '0;
      r_tick_d  <= 1'b0;
      led       <= '0;
      step      <= 1'b0;
    end else begin
      r_pwm <= r_pwm + PWM_BITS'(1);
      led   <= w_pattern;
      // step is delayed one cycle so it lines up with the led value it announces
      r_tick_d <= w_tick && !w_mode_chg && (r_mode_q != M_OFF);
      step     <= r_tick_d;

      if (w_mode_chg) begin
        r_mode_q  <= mode_e'(mode);
        r_presc   <= '0;
        r_cnt     <= '0;
        r_pos     <= '0;
        r_dir_up  <= 1'b1;
        r_duty    <= '0;
        r_ddir_up <= 1'b1;
      end else begin
        if (!pause) begin
          r_presc <= (r_presc == PRESC_MAX) ? '0 : r_presc + PRESC_W'(1);
        end
        if (w_tick) begin
          case (r_mode_q)
            M_BINARY: r_cnt <= r_cnt + CHANNELS'(1);
            M_SCAN: begin
              if (SINGLE_CH) begin
                r_pos <= '0;
              end else if (r_dir_up) begin
                if (r_pos == POS_MAX) begin
                  r_pos    <= r_pos - POS_W'(1);
                  r_dir_up <= 1'b0;
                end else begin
                  r_pos <= r_pos + POS_W'(1);
                end
              end else begin
                if (r_pos == '0) begin
                  r_pos    <= POS_W'(1);
                  r_dir_up <= 1'b1;
                end else begin
                  r_pos <= r_pos - POS_W'(1);
                end
              end
            end
            M_BREATHE: begin
              if (r_ddir_up) begin
                if (r_duty == DUTY_MAX) begin
                  r_duty    <= r_duty - PWM_BITS'(1);
                  r_ddir_up <= 1'b0;
                end else begin
                  r_duty <= r_duty + PWM_BITS'(1);
                end
              end else begin
                if (r_duty == '0) begin
                  r_duty    <= PWM_BITS'(1);
                  r_ddir_up <= 1'b1;
                end else begin
                  r_duty <= r_duty - PWM_BITS'(1);
                end
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen: a 4-channel and a 1-channel instance
// share stimulus; outputs are packed as {step_b, led_b, step_a, led_a}.
module tb_led_pattern_gen;

  logic       clk;
  logic       rst_n;
  logic [1:0] mode;
  logic       pause;
  logic [3:0] led_a;
  logic       step_a;
  logic [0:0] led_b;
  logic       step_b;

  int vectors;
  int miscompares;

  led_pattern_gen #(.CHANNELS(4), .TICK_DIV(4), .PWM_BITS(3)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .mode(mode), .pause(pause), .led(led_a), .step(step_a)
  );

  led_pattern_gen #(.CHANNELS(1), .TICK_DIV(4), .PWM_BITS(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .mode(mode), .pause(pause), .led(led_b), .step(step_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] mode;
    logic       pause;
    logic [7:0] exp;
  } vec_t;

  localparam int PHASE_LEN = 70;
  vec_t vecs[3*PHASE_LEN];

  function automatic logic [7:0] act_vec();
    return {1'b0, step_b, led_b[0], step_a, led_a};
  endfunction

  // Scan position after n steps: 0,1,2,3,2,1,0,...
  function automatic int scan_pos(input int n);
    int r;
    r = n % 6;
    return (r <= 3) ? r : 6 - r;
  endfunction

  // Breathe duty after n steps: 0..7,6..0,1,...
  function automatic int duty_of(input int n);
    int r;
    r = n % 14;
    return (r <= 7) ? r : 14 - r;
  endfunction

  // Expected outputs k clocks after reset release with mode m held constant.
  function automatic logic [7:0] expect_vec(input logic [1:0] m, input int k);
    int n;
    logic [3:0] la;
    logic lb;
    logic st;
    n  = (k >= 6) ? (k - 6) / 4 + 1 : 0;
    st = (k >= 6) && ((k - 6) % 4 == 0);
    la = '0;
    lb = 1'b0;
    case (m)
      2'd1: begin la = 4'(n % 16); lb = 1'(n % 2); end
      2'd2: if (k >= 2) begin la = 4'b0001 << scan_pos(n); lb = 1'b1; end
      2'd3: if (k >= 2) begin lb = (((k - 1) % 8) < duty_of(n)); la = {4{lb}}; end
      default: st = 1'b0;
    endcase
    return {1'b0, st, lb, st, la};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input logic [1:0] m);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    pause = 1'b0;
    mode  = m;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic breathe_window(input int target);
    int ones;
    int bad;
    apply_reset(2'd3);
    repeat (1 + 4 * target) cyc();
    pause = 1'b1;
    ones  = 0;
    bad   = 0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      ones += int'(led_a[0]);
      if (led_a != {4{led_a[0]}} || led_b[0] != led_a[0]) bad++;
    end
    pause = 1'b0;
    check($sformatf("breathe_ones_duty%0d", target), 8'(ones), 8'(target));
    check($sformatf("breathe_bits_equal_duty%0d", target), 8'(bad), 8'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [1:0] pm;
    vectors     = 0;
    miscompares = 0;
    rst_n = 1'b0;
    mode  = 2'd0;
    pause = 1'b0;

    for (int p = 0; p < 3; p++) begin
      pm = 2'(p + 1);
      for (int k = 1; k <= PHASE_LEN; k++) begin
        vecs[p*PHASE_LEN + k - 1].mode  = pm;
        vecs[p*PHASE_LEN + k - 1].pause = 1'b0;
        vecs[p*PHASE_LEN + k - 1].exp   = expect_vec(pm, k);
      end
    end

    #2;
    check("reset_state", act_vec(), 8'h00);

    // Table: BINARY, SCAN, BREATHE each run from reset release.
    for (int i = 0; i < 3*PHASE_LEN; i++) begin
      if (i % PHASE_LEN == 0) apply_reset(vecs[i].mode);
      mode  = vecs[i].mode;
      pause = vecs[i].pause;
      cyc();
      check($sformatf("table_m%0d_k%0d", vecs[i].mode, i % PHASE_LEN + 1), act_vec(), vecs[i].exp);
    end

    // Pause in BINARY raised while presc sits at its last count, cnt = 5.
    apply_reset(2'd1);
    repeat (24) cyc();
    check("pause_pre_led5", act_vec(), {1'b0, 1'b0, 1'b1, 1'b0, 4'd5});
    pause = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      check($sformatf("pause_hold_%0d", i), act_vec(), {1'b0, 1'b0, 1'b1, 1'b0, 4'd5});
    end
    pause = 1'b0;
    cyc();
    check("pause_release_tick", act_vec(), {1'b0, 1'b0, 1'b1, 1'b0, 4'd5});
    cyc();
    check("pause_release_step6", act_vec(), {1'b0, 1'b1, 1'b0, 1'b1, 4'd6});

    // Asynchronous reset while step is high and led is nonzero.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", act_vec(), 8'h00);

    // BINARY -> SCAN exactly on a tick edge, then SCAN -> OFF.
    apply_reset(2'd1);
    repeat (12) cyc();
    mode = 2'd2;
    cyc();
    check("modesw_no_incr", act_vec(), {1'b0, 1'b0, 1'b0, 1'b0, 4'd2});
    for (int i = 0; i < 4; i++) begin
      cyc();
      check($sformatf("modesw_scan_init_%0d", i), act_vec(), {1'b0, 1'b0, 1'b1, 1'b0, 4'b0001});
    end
    cyc();
    check("modesw_first_scan_step", act_vec(), {1'b0, 1'b1, 1'b1, 1'b1, 4'b0010});
    mode = 2'd0;
    cyc();
    check("off_transition", act_vec(), {1'b0, 1'b0, 1'b1, 1'b0, 4'b0010});
    for (int i = 0; i < 12; i++) begin
      cyc();
      check($sformatf("off_idle_%0d", i), act_vec(), 8'h00);
    end

    // BREATHE duty windows with the pattern frozen by pause.
    breathe_window(0);
    breathe_window(3);
    breathe_window(7);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
